// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state encoding and SYNC constant for the USB TX serializer.
package usb_tx_pkg;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} tx_state_t;
    localparam logic [7:0] USB_SYNC_RAW = 8'h80;
endpackage

// File: rtl/usb_tx_byte_shifter.sv
// usb_tx_byte_shifter: LSB-first byte shift register with bit counter.
module usb_tx_byte_shifter (
    input  logic       clk12,
    input  logic       RST,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] load_data,
    output logic       bit0,
    output logic       byte_done
);
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        shift_d   = load ? load_data : shift ? {1'b0, shift_q[7:1]} : shift_q;
        bit_cnt_d = load ? 3'd0 : shift ? bit_cnt_q + 3'd1 : bit_cnt_q;
        bit0      = shift_q[0];
        byte_done = bit_cnt_q == 3'd7;
    end

    always_ff @(posedge clk12) begin
        if (RST) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end
endmodule

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: frames SYNC, LSB-first payload bytes and EOP onto the bit-stuffer path,
// stalling on stuff-bit insertion and truncating to EOP on byte underrun.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = USB_SYNC_RAW,
    parameter int         EOP_SE0_BITS = 2
) (
    input  logic       clk12,
    input  logic       RST,
    input  logic       txReqSend,
    input  logic [7:0] txData,
    input  logic       txDataValid,
    input  logic       txIsLastByte,
    output logic       txDataReady,
    input  logic       stuffReady,
    output logic       stuffData,
    output logic       stuffRst,
    output logic       txActive,
    output logic       txSe0,
    output logic       txEopJ,
    output logic       txDone,
    output logic       txError
);
    localparam int CW = EOP_SE0_BITS > 1 ? $clog2(EOP_SE0_BITS) : 1;
    localparam logic [CW-1:0] EOP_LAST = CW'(EOP_SE0_BITS - 1);

    tx_state_t state_q, state_d;
    logic last_q, last_d;
    logic [CW-1:0] eop_cnt_q, eop_cnt_d;
    logic bit0, byte_done, in_bits, at_bound, end_pkt, load, shift;
    logic [7:0] load_data;

    usb_tx_byte_shifter u_shifter (
        .clk12(clk12), .RST(RST), .load(load), .shift(shift),
        .load_data(load_data), .bit0(bit0), .byte_done(byte_done)
    );

    always_comb begin
        in_bits     = state_q == SYNC || state_q == DATA;
        at_bound    = in_bits && byte_done && stuffReady;
        end_pkt     = state_q == DATA && last_q;
        txDataReady = at_bound && !end_pkt && txDataValid;
        txError     = at_bound && !end_pkt && !txDataValid;
        load        = (state_q == IDLE && txReqSend) || txDataReady;
        load_data   = state_q == IDLE ? SYNC_PATTERN : txData;
        shift       = in_bits && stuffReady;
        txActive    = state_q != IDLE;
        // A low stuffReady in EOP_SE0 is a stuff bit still owed from the last data bit
        txSe0       = state_q == EOP_SE0 && stuffReady;
        txEopJ      = state_q == EOP_J;
        txDone      = txEopJ;
        stuffRst    = state_q == IDLE || txSe0 || txEopJ;
        stuffData   = in_bits && bit0;
        last_d      = txDataReady ? txIsLastByte : last_q;
        eop_cnt_d   = txSe0 ? eop_cnt_q + 1'b1 : state_q == EOP_SE0 ? eop_cnt_q : '0;
        state_d     = state_q;
        case (state_q)
            IDLE:       if (txReqSend) state_d = SYNC;
            SYNC, DATA: if (at_bound) state_d = txDataReady ? DATA : EOP_SE0;
            EOP_SE0:    if (txSe0 && eop_cnt_q == EOP_LAST) state_d = EOP_J;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk12) begin
        if (RST) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            eop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            eop_cnt_q <= eop_cnt_d;
        end
    end
endmodule
